// File: rtl/leaf_replay_buffer.sv
// leaf_replay_buffer
//
// Sits between a leaf shell's packet output and the BFT pi switch port. In pass-through
// it forwards each packet with one cycle of latency and keeps a ring-buffer copy of the
// most recent valid packets. A rising edge on resend replays the stored packets
// oldest-first. A clear pulse from the leaf releases the stored packets.
//
// Ports:
//   clk          leaf network clock, rising edge
//   reset_n      synchronous active-low reset
//   din_pkt      packet from the leaf; din_pkt[PACKET_BITS-1] is the valid flag
//   resend       level replay request from the network controller
//   clear        one-cycle pulse that empties the buffer
//   dout_pkt     packet toward the BFT
//   replay_busy  high while replaying
//   occupancy    number of stored packets, 0..DEPTH
//   drop_cnt     saturating count of valid packets discarded while not in pass-through
module leaf_replay_buffer #(
   parameter int unsigned PACKET_BITS   = 49,
   parameter int unsigned NUM_ADDR_BITS = 4,
   parameter int unsigned DROP_CNT_BITS = 16
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [PACKET_BITS-1:0]   din_pkt,
   input  logic                     resend,
   input  logic                     clear,
   output logic [PACKET_BITS-1:0]   dout_pkt,
   output logic                     replay_busy,
   output logic [NUM_ADDR_BITS:0]   occupancy,
   output logic [DROP_CNT_BITS-1:0] drop_cnt
);

   localparam int unsigned DEPTH = 1 << NUM_ADDR_BITS;
   localparam logic [NUM_ADDR_BITS:0] OCC_FULL = {1'b1, {NUM_ADDR_BITS{1'b0}}};

   localparam logic [1:0] ST_PASS   = 2'd0;
   localparam logic [1:0] ST_REPLAY = 2'd1;
   localparam logic [1:0] ST_HOLD   = 2'd2;

   logic [PACKET_BITS-1:0]   mem [DEPTH];

   logic [1:0]               state, state_d;
   logic                     resend_q;
   logic [NUM_ADDR_BITS-1:0] wr_ptr, wr_ptr_d;
   logic [NUM_ADDR_BITS-1:0] rd_ptr, rd_ptr_d;
   logic [NUM_ADDR_BITS:0]   remaining, remaining_d;
   logic [NUM_ADDR_BITS:0]   occupancy_d;
   logic [DROP_CNT_BITS-1:0] drop_cnt_d;
   logic [PACKET_BITS-1:0]   dout_pkt_d;
   logic                     mem_we;
   logic                     din_valid;
   logic                     rise;

   assign din_valid = din_pkt[PACKET_BITS-1];
   assign rise      = resend & ~resend_q;

   always_comb begin
      state_d     = state;
      wr_ptr_d    = wr_ptr;
      rd_ptr_d    = rd_ptr;
      remaining_d = remaining;
      occupancy_d = occupancy;
      drop_cnt_d  = drop_cnt;
      dout_pkt_d  = '0;
      mem_we      = 1'b0;

      case (state)
         ST_PASS: begin
            dout_pkt_d = din_valid ? din_pkt : '0;
            // clear beats a same-cycle store; the packet is still forwarded
            if (clear) begin
               occupancy_d = '0;
            end else if (din_valid) begin
               mem_we   = 1'b1;
               wr_ptr_d = wr_ptr + 1'b1;
               if (occupancy != OCC_FULL) begin
                  occupancy_d = occupancy + 1'b1;
               end
            end
            // Latch the replay window from post-store values so the packet stored in the
            // rise cycle is part of the replay. With a full buffer the subtraction wraps
            // to the oldest entry.
            if (rise) begin
               if (occupancy_d == '0) begin
                  state_d = ST_HOLD;
               end else begin
                  state_d     = ST_REPLAY;
                  rd_ptr_d    = wr_ptr_d - occupancy_d[NUM_ADDR_BITS-1:0];
                  remaining_d = occupancy_d;
               end
            end
         end
         ST_REPLAY: begin
            dout_pkt_d  = mem[rd_ptr];
            rd_ptr_d    = rd_ptr + 1'b1;
            remaining_d = remaining - 1'b1;
            if (remaining == {{NUM_ADDR_BITS{1'b0}}, 1'b1}) begin
               state_d = resend ? ST_HOLD : ST_PASS;
            end
         end
         ST_HOLD: begin
            if (!resend) begin
               state_d = ST_PASS;
            end
         end
         default: begin
            state_d = ST_PASS;
         end
      endcase

      // Outside pass-through the buffer is frozen except for clear, and inputs are dropped
      if (state != ST_PASS) begin
         if (clear) begin
            occupancy_d = '0;
         end
         if (din_valid && (drop_cnt != '1)) begin
            drop_cnt_d = drop_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= ST_PASS;
         resend_q    <= 1'b0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         remaining   <= '0;
         occupancy   <= '0;
         drop_cnt    <= '0;
         dout_pkt    <= '0;
         replay_busy <= 1'b0;
      end else begin
         state       <= state_d;
         resend_q    <= resend;
         wr_ptr      <= wr_ptr_d;
         rd_ptr      <= rd_ptr_d;
         remaining   <= remaining_d;
         occupancy   <= occupancy_d;
         drop_cnt    <= drop_cnt_d;
         dout_pkt    <= dout_pkt_d;
         replay_busy <= (state_d == ST_REPLAY);
      end
   end

   // Storage is not reset; contents only matter once occupancy covers them
   always_ff @(posedge clk) begin
      if (reset_n && mem_we) begin
         mem[wr_ptr] <= din_pkt;
      end
   end

endmodule

// File: tb/tb_leaf_replay_buffer.sv
// tb_leaf_replay_buffer
//
// Directed scenarios followed by random traffic, checked each cycle against a
// queue-based reference model of the replay buffer.
module tb_leaf_replay_buffer;

   localparam int unsigned PB    = 49;
   localparam int unsigned NA    = 4;
   localparam int unsigned DC    = 16;
   localparam int unsigned DEPTH = 1 << NA;

   localparam int M_PASS   = 0;
   localparam int M_REPLAY = 1;
   localparam int M_HOLD   = 2;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [PB-1:0] din_pkt;
   logic          resend;
   logic          clear;
   logic [PB-1:0] dout_pkt;
   logic          replay_busy;
   logic [NA:0]   occupancy;
   logic [DC-1:0] drop_cnt;

   int vectors     = 0;
   int miscompares = 0;

   // reference model state
   int            mode = M_PASS;
   logic [PB-1:0] stored[$];
   logic [PB-1:0] rlist[$];
   logic          prev_rs = 1'b0;
   logic [PB-1:0] e_dout  = '0;
   logic          e_busy  = 1'b0;
   logic [DC-1:0] e_drop  = '0;

   always #5 clk = ~clk;

   leaf_replay_buffer #(
      .PACKET_BITS  (PB),
      .NUM_ADDR_BITS(NA),
      .DROP_CNT_BITS(DC)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .din_pkt    (din_pkt),
      .resend     (resend),
      .clear      (clear),
      .dout_pkt   (dout_pkt),
      .replay_busy(replay_busy),
      .occupancy  (occupancy),
      .drop_cnt   (drop_cnt)
   );

   function automatic logic [PB-1:0] pkt(input int unsigned n);
      pkt = {1'b1, 48'(n)};
   endfunction

   task automatic model_edge(input logic [PB-1:0] d, input logic rs, input logic clr,
                             input logic rstn);
      logic valid;
      logic rise;
      if (!rstn) begin
         mode    = M_PASS;
         stored.delete();
         rlist.delete();
         prev_rs = 1'b0;
         e_dout  = '0;
         e_drop  = '0;
      end else begin
         valid = d[PB-1];
         rise  = rs && !prev_rs;
         if (mode == M_PASS) begin
            e_dout = valid ? d : '0;
            if (clr) begin
               stored.delete();
            end else if (valid) begin
               stored.push_back(d);
               if (stored.size() > DEPTH) void'(stored.pop_front());
            end
            if (rise) begin
               if (stored.size() == 0) begin
                  mode = M_HOLD;
               end else begin
                  rlist = stored;
                  mode  = M_REPLAY;
               end
            end
         end else begin
            if (mode == M_REPLAY) begin
               e_dout = rlist.pop_front();
               if (rlist.size() == 0) mode = rs ? M_HOLD : M_PASS;
            end else begin
               e_dout = '0;
               if (!rs) mode = M_PASS;
            end
            if (clr) stored.delete();
            if (valid && (e_drop != '1)) e_drop = e_drop + 1'b1;
         end
         prev_rs = rs;
      end
      e_busy = (mode == M_REPLAY);
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic [PB-1:0] d, input logic rs, input logic clr,
                       input logic rstn);
      din_pkt = d;
      resend  = rs;
      clear   = clr;
      reset_n = rstn;
      @(posedge clk);
      model_edge(d, rs, clr, rstn);
      #1;
      check("dout_pkt", 64'(dout_pkt), 64'(e_dout));
      check("replay_busy", 64'(replay_busy), 64'(e_busy));
      check("occupancy", 64'(occupancy), 64'(stored.size()));
      check("drop_cnt", 64'(drop_cnt), 64'(e_drop));
   endtask

   initial begin
      logic          rs;
      logic          clr;
      logic          rstn;
      logic [PB-1:0] d;
      int            busy_cycles;

      din_pkt = '0;
      resend  = 1'b0;
      clear   = 1'b0;
      reset_n = 1'b0;

      // reset
      step('0, 0, 0, 0);
      step('0, 0, 0, 0);
      check("reset_dout", 64'(dout_pkt), 64'd0);
      check("reset_occ", 64'(occupancy), 64'd0);

      // three packets forwarded and stored
      for (int i = 1; i <= 3; i++) step(pkt(i), 0, 0, 1);
      check("fwd_pkt3", 64'(dout_pkt), 64'(pkt(3)));
      step('0, 0, 0, 1);
      step('0, 0, 0, 1);
      check("occ_three", 64'(occupancy), 64'd3);
      check("drop_zero", 64'(drop_cnt), 64'd0);

      // resend held for 10 cycles: 3-packet replay, then hold, then pass
      busy_cycles = 0;
      for (int i = 0; i < 10; i++) begin
         step('0, 1, 0, 1);
         if (replay_busy) busy_cycles++;
      end
      check("busy_cycles", 64'(busy_cycles), 64'd3);
      for (int i = 0; i < 3; i++) step('0, 0, 0, 1);
      check("occ_after_replay", 64'(occupancy), 64'd3);

      // overfill: 20 packets into a 16-deep ring, replay keeps packets 5..20
      step('0, 0, 1, 1);
      for (int i = 1; i <= 20; i++) step(pkt(i), 0, 0, 1);
      step('0, 0, 0, 1);
      check("occ_full", 64'(occupancy), 64'(DEPTH));
      step('0, 1, 0, 1);
      step('0, 1, 0, 1);
      check("first_replayed", 64'(dout_pkt), 64'(pkt(5)));
      for (int i = 0; i < 15; i++) step('0, 1, 0, 1);
      check("last_replayed", 64'(dout_pkt), 64'(pkt(20)));

      // valid packets during hold are dropped
      for (int i = 0; i < 4; i++) step(pkt(100 + i), 1, 0, 1);
      check("drop_four", 64'(drop_cnt), 64'd4);
      check("occ_frozen", 64'(occupancy), 64'(DEPTH));
      step('0, 0, 0, 1);
      step('0, 0, 0, 1);

      // clear then resend: no replay, straight to hold
      for (int i = 1; i <= 5; i++) step(pkt(200 + i), 0, 0, 1);
      step('0, 0, 1, 1);
      check("occ_cleared", 64'(occupancy), 64'd0);
      for (int i = 0; i < 4; i++) step('0, 1, 0, 1);
      check("no_busy_after_clear", 64'(replay_busy), 64'd0);
      step('0, 0, 0, 1);
      step('0, 0, 0, 1);

      // clear coincident with the resend rise
      for (int i = 1; i <= 5; i++) step(pkt(300 + i), 0, 0, 1);
      step('0, 1, 1, 1);
      for (int i = 0; i < 3; i++) step('0, 1, 0, 1);
      check("no_busy_clear_rise", 64'(replay_busy), 64'd0);
      step('0, 0, 0, 1);
      step('0, 0, 0, 1);

      // reset during a replay after two packets have left
      step('0, 0, 1, 1);
      for (int i = 1; i <= 6; i++) step(pkt(400 + i), 0, 0, 1);
      step('0, 0, 0, 1);
      step('0, 1, 0, 1);
      step('0, 1, 0, 1);
      step('0, 1, 0, 1);
      check("second_of_six", 64'(dout_pkt), 64'(pkt(402)));
      step('0, 0, 0, 0);
      check("rst_busy", 64'(replay_busy), 64'd0);
      check("rst_occ", 64'(occupancy), 64'd0);
      step(pkt(500), 0, 0, 1);
      check("fwd_after_rst", 64'(dout_pkt), 64'(pkt(500)));
      step('0, 0, 0, 1);

      // random traffic
      rs = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 99) < 10) rs = ~rs;
         clr  = ($urandom_range(0, 99) < 4);
         rstn = ($urandom_range(0, 299) != 0);
         if ($urandom_range(0, 99) < 60) d = {1'b1, 16'($urandom), 32'($urandom)};
         else d = '0;
         step(d, rs, clr, rstn);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
